// File: rtl/mem_stage_dmem_if.sv
// rtl/mem_stage_dmem_if.sv - EX/MEM to MEM/WB handshake and access bundle for the data-memory stage
interface mem_stage_dmem_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              ld_unsigned;
  logic [ADDR_W-1:0] alu_result;
  logic [31:0]       store_data;
  logic              out_valid;
  logic [31:0]       mem_out;
  logic              fault;
  logic              busy;

  // Upstream pipeline side: issues instructions, observes results
  modport master (
    output in_valid, mem_read, mem_write, size, ld_unsigned, alu_result, store_data,
    input  in_ready, out_valid, mem_out, fault, busy
  );

  // Memory stage side
  modport slave (
    input  in_valid, mem_read, mem_write, size, ld_unsigned, alu_result, store_data,
    output in_ready, out_valid, mem_out, fault, busy
  );
endinterface

// File: rtl/mem_stage_dmem.sv
// rtl/mem_stage_dmem.sv - MEM-stage data memory with sized loads/stores, extension, endianness and init clear
module mem_stage_dmem #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 32,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input logic             clk,
  input logic             reset,
  mem_stage_dmem_if.slave bus
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WA_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH_BYTES);
  localparam logic [WA_W-1:0]   LAST_WORD = WA_W'(WORDS - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  logic [WA_W-1:0] init_ptr;   // word index being cleared (byte pointer / 4)
  logic [31:0]     mem [WORDS]; // byte at word offset k lives in bits [8k+7:8k]

  logic [2:0]      nbytes;
  logic [1:0]      off;
  logic [WA_W-1:0] widx;
  logic [ADDR_W:0] last_byte;
  logic            misaligned;
  logic            in_range;
  logic            is_mem;
  logic            legal;
  logic [31:0]     rword;
  logic [31:0]     raw;
  logic [31:0]     ld_data;
  logic [31:0]     wword;

  // Significance (byte index from LSB of the value) of the j-th byte of an n-byte access
  function automatic int sig_of(input int j, input int n);
    return BIG_ENDIAN ? (n - 1 - j) : j;
  endfunction

  // Storage lane of the j-th byte of an access starting at word offset o
  function automatic int lane_of(input logic [1:0] o, input int j);
    logic [1:0] l;
    l = o + j[1:0];
    return int'(l);
  endfunction

  assign widx         = bus.alu_result[WA_W+1:2];
  assign bus.in_ready = (state == RUN);
  assign bus.busy     = (state == INIT);

  // Decode legality, gather load bytes and merge store bytes into the addressed word
  always_comb begin
    case (bus.size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    off        = bus.alu_result[1:0];
    misaligned = ((bus.size == 2'b01) && off[0]) || ((bus.size == 2'b10) && (off != 2'b00));
    last_byte  = {1'b0, bus.alu_result} + (ADDR_W + 1)'(nbytes - 3'd1);
    in_range   = (last_byte < DEPTH_L);
    is_mem     = bus.mem_read | bus.mem_write;
    legal      = !is_mem || ((bus.size != 2'b11) && !(bus.mem_read && bus.mem_write)
                             && !misaligned && in_range);
    rword      = in_range ? mem[widx] : '0;
    raw        = '0;
    wword      = rword;
    for (int j = 0; j < 4; j++) begin
      if (j < int'(nbytes)) begin
        raw[8*sig_of(j, int'(nbytes)) +: 8]   = rword[8*lane_of(off, j) +: 8];
        wword[8*lane_of(off, j) +: 8]         = bus.store_data[8*sig_of(j, int'(nbytes)) +: 8];
      end
    end
    case (bus.size)
      2'b00:   ld_data = bus.ld_unsigned ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ld_data = bus.ld_unsigned ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ld_data = raw;
    endcase
  end

  // Init/run FSM: clears one word per cycle after reset, then serves accesses with registered results
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= INIT;
      init_ptr      <= '0;
      bus.out_valid <= 1'b0;
      bus.mem_out   <= '0;
      bus.fault     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          mem[init_ptr] <= '0;
          bus.out_valid <= 1'b0;
          if (init_ptr == LAST_WORD) begin
            state <= RUN;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        RUN: begin
          bus.out_valid <= bus.in_valid;
          if (bus.in_valid) begin
            if (!legal) begin
              bus.fault   <= 1'b1;
              bus.mem_out <= '0;
            end else begin
              bus.fault   <= 1'b0;
              bus.mem_out <= bus.mem_read ? ld_data : bus.alu_result[31:0];
              if (bus.mem_write) begin
                mem[widx] <= wword;
              end
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_dmem.sv
// tb/tb_mem_stage_dmem.sv - table-driven and randomized check of mem_stage_dmem in both endiannesses
module tb_mem_stage_dmem;
  localparam int DEPTH = 256;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_stage_dmem_if #(.ADDR_W(32)) if_be ();
  mem_stage_dmem_if #(.ADDR_W(32)) if_le ();

  mem_stage_dmem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .bus(if_be.slave)
  );
  mem_stage_dmem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .bus(if_le.slave)
  );

  typedef struct {
    string       name;
    logic        v;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sd;
    int          tgt;     // 0: big-endian instance, 1: little-endian, -1: model only
    logic        ev;
    logic [31:0] eout;
    logic        ef;
  } vec_t;

  // Byte-addressed reference memories and last-result registers, one per instance
  logic [7:0]  ref_mem [2][DEPTH];
  logic [31:0] pout [2];
  logic        pfault [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] dut_vec(input int d);
    if (d == 0) return {if_be.out_valid, if_be.fault, if_be.mem_out};
    return {if_le.out_valid, if_le.fault, if_le.mem_out};
  endfunction

  function automatic vec_t mk(input string name, input logic v, rd, wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr, sd, input int tgt,
                              input logic [31:0] eout, input logic ef);
    vec_t x;
    x.name = name; x.v = v; x.rd = rd; x.wr = wr; x.sz = sz; x.uns = uns;
    x.addr = addr; x.sd = sd; x.tgt = tgt; x.ev = v; x.eout = eout; x.ef = ef;
    return x;
  endfunction

  task automatic drive(input logic v, rd, wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, sd);
    if_be.in_valid = v;  if_be.mem_read = rd; if_be.mem_write = wr; if_be.size = sz;
    if_be.ld_unsigned = uns; if_be.alu_result = addr; if_be.store_data = sd;
    if_le.in_valid = v;  if_le.mem_read = rd; if_le.mem_write = wr; if_le.size = sz;
    if_le.ld_unsigned = uns; if_le.alu_result = addr; if_le.store_data = sd;
  endtask

  // Behavioural model: byte-level memory, plain arithmetic on addresses and values
  task automatic model_step(input int d, input vec_t x, output logic [33:0] e);
    longint      n;
    longint      a;
    logic [31:0] val;
    logic        bad;
    int          sig;
    if (!x.v) begin
      e = {1'b0, pfault[d], pout[d]};
    end else begin
      n   = (x.sz == 2'b00) ? 1 : (x.sz == 2'b01) ? 2 : 4;
      a   = longint'({32'b0, x.addr});
      bad = (x.sz == 2'b11) || (x.rd && x.wr) || (a % n != 0) || (a + n > DEPTH);
      if (!(x.rd || x.wr)) begin
        pout[d] = x.addr; pfault[d] = 1'b0;
      end else if (bad) begin
        pout[d] = 32'h0; pfault[d] = 1'b1;
      end else if (x.wr) begin
        for (int j = 0; j < n; j++) begin
          sig = (d == 0) ? int'(n) - 1 - j : j;
          ref_mem[d][a + j] = 8'((x.sd >> (8 * sig)) & 32'hFF);
        end
        pout[d] = x.addr; pfault[d] = 1'b0;
      end else begin
        val = 32'h0;
        for (int j = 0; j < n; j++) begin
          sig = (d == 0) ? int'(n) - 1 - j : j;
          val = val | (32'(ref_mem[d][a + j]) << (8 * sig));
        end
        if (n < 4 && !x.uns && val[8 * n - 1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
        pout[d] = val; pfault[d] = 1'b0;
      end
      e = {1'b1, pfault[d], pout[d]};
    end
  endtask

  // One instruction per cycle: drive on the falling edge, check just after the accepting edge
  task automatic step(input vec_t x);
    logic [33:0] e0;
    logic [33:0] e1;
    @(negedge clk);
    drive(x.v, x.rd, x.wr, x.sz, x.uns, x.addr, x.sd);
    chk({x.name, "/in_ready"}, {33'b0, if_be.in_ready & if_le.in_ready}, 34'd1);
    @(posedge clk);
    model_step(0, x, e0);
    model_step(1, x, e1);
    #1;
    chk({x.name, "/be_model"}, dut_vec(0), e0);
    chk({x.name, "/le_model"}, dut_vec(1), e1);
    if (x.tgt >= 0) chk({x.name, "/table"}, dut_vec(x.tgt), {x.ev, x.ef, x.eout});
  endtask

  // Reset (optionally with a store presented alongside it), then time the init sweep
  task automatic do_reset(input logic with_store);
    int cnt;
    @(negedge clk);
    reset = 1'b1;
    drive(with_store, 1'b0, with_store, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = 8'h00;
      pout[d] = 32'h0; pfault[d] = 1'b0;
    end
    chk("reset_be_outputs", dut_vec(0), 34'd0);
    chk("reset_le_outputs", dut_vec(1), 34'd0);
    chk("reset_busy", {32'b0, if_be.busy, if_le.busy}, 34'd3);
    chk("reset_in_ready", {32'b0, if_be.in_ready, if_le.in_ready}, 34'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    cnt = 0;
    while ((if_be.busy || if_le.busy) && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("init_busy_cycles", 34'(cnt), 34'd64);
    chk("init_done_ready", {32'b0, if_be.in_ready, if_le.in_ready}, 34'd3);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t r;
    int   kind;
    int   asel;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    //           name          v   rd  wr  sz     uns  addr          store_data    tgt exp_out        fault
    tbl.push_back(mk("T1_lw0",     1, 1, 0, 2'b10, 0, 32'h0,        32'h0,        0, 32'h00000000, 0));
    tbl.push_back(mk("T2_sw8",     1, 0, 1, 2'b10, 0, 32'h8,        32'hBC0019D4, 0, 32'h00000008, 0));
    tbl.push_back(mk("T2_lb8",     1, 1, 0, 2'b00, 0, 32'h8,        32'h0,        0, 32'hFFFFFFBC, 0));
    tbl.push_back(mk("T2_lbu8",    1, 1, 0, 2'b00, 1, 32'h8,        32'h0,        0, 32'h000000BC, 0));
    tbl.push_back(mk("T2_lhA",     1, 1, 0, 2'b01, 0, 32'hA,        32'h0,        0, 32'h000019D4, 0));
    tbl.push_back(mk("T2_lw8",     1, 1, 0, 2'b10, 0, 32'h8,        32'h0,        0, 32'hBC0019D4, 0));
    tbl.push_back(mk("le_lhA",     1, 1, 0, 2'b01, 0, 32'hA,        32'h0,        1, 32'hFFFFBC00, 0));
    tbl.push_back(mk("T3_swC",     1, 0, 1, 2'b10, 0, 32'hC,        32'hACD50000, 1, 32'h0000000C, 0));
    tbl.push_back(mk("T3_lbuC",    1, 1, 0, 2'b00, 1, 32'hC,        32'h0,        1, 32'h00000000, 0));
    tbl.push_back(mk("T3_lbuF",    1, 1, 0, 2'b00, 1, 32'hF,        32'h0,        1, 32'h000000AC, 0));
    tbl.push_back(mk("T4_lw6",     1, 1, 0, 2'b10, 0, 32'h6,        32'h0,        0, 32'h00000000, 1));
    tbl.push_back(mk("T4_lh3",     1, 1, 0, 2'b01, 0, 32'h3,        32'h0,        0, 32'h00000000, 1));
    tbl.push_back(mk("T4_sw100",   1, 0, 1, 2'b10, 0, 32'h100,      32'hFFFFFFFF, 0, 32'h00000000, 1));
    tbl.push_back(mk("T4_sz3",     1, 1, 0, 2'b11, 0, 32'h8,        32'h0,        0, 32'h00000000, 1));
    tbl.push_back(mk("T4_rdwr",    1, 1, 1, 2'b10, 0, 32'h8,        32'h11111111, 0, 32'h00000000, 1));
    tbl.push_back(mk("T4_hold",    0, 1, 0, 2'b10, 0, 32'h8,        32'h0,        0, 32'h00000000, 1));
    tbl.push_back(mk("T4_lw8",     1, 1, 0, 2'b10, 0, 32'h8,        32'h0,        0, 32'hBC0019D4, 0));
    tbl.push_back(mk("T4_lw4",     1, 1, 0, 2'b10, 0, 32'h4,        32'h0,        0, 32'h00000000, 0));
    tbl.push_back(mk("T4_sw_sz3",  1, 0, 1, 2'b11, 0, 32'h20,       32'h55555555, 0, 32'h00000000, 1));
    tbl.push_back(mk("T4_lw20",    1, 1, 0, 2'b10, 0, 32'h20,       32'h0,        0, 32'h00000000, 0));
    tbl.push_back(mk("hi_addr",    1, 1, 0, 2'b10, 0, 32'h80000008, 32'h0,        0, 32'h00000000, 1));
    tbl.push_back(mk("edge_lwFC",  1, 1, 0, 2'b10, 0, 32'hFC,       32'h0,        0, 32'h00000000, 0));
    tbl.push_back(mk("edge_lbFF",  1, 1, 0, 2'b00, 0, 32'hFF,       32'h0,        0, 32'h00000000, 0));
    tbl.push_back(mk("edge_lhFF",  1, 1, 0, 2'b01, 0, 32'hFF,       32'h0,        0, 32'h00000000, 1));
    tbl.push_back(mk("edge_sh100", 1, 0, 1, 2'b01, 0, 32'h100,      32'h1234,     0, 32'h00000000, 1));
    tbl.push_back(mk("sh14",       1, 0, 1, 2'b01, 0, 32'h14,       32'h1234ABCD, 0, 32'h00000014, 0));
    tbl.push_back(mk("lbu15",      1, 1, 0, 2'b00, 1, 32'h15,       32'h0,        0, 32'h000000CD, 0));
    tbl.push_back(mk("lh14",       1, 1, 0, 2'b01, 0, 32'h14,       32'h0,        0, 32'hFFFFABCD, 0));
    tbl.push_back(mk("lhu14",      1, 1, 0, 2'b01, 1, 32'h14,       32'h0,        0, 32'h0000ABCD, 0));
    tbl.push_back(mk("sb17",       1, 0, 1, 2'b00, 0, 32'h17,       32'hAAAAAA7F, 0, 32'h00000017, 0));
    tbl.push_back(mk("lw14",       1, 1, 0, 2'b10, 0, 32'h14,       32'h0,        0, 32'hABCD007F, 0));
    tbl.push_back(mk("le_lbu15",   1, 1, 0, 2'b00, 1, 32'h15,       32'h0,        1, 32'h000000AB, 0));
    tbl.push_back(mk("T5_pass",    1, 0, 0, 2'b10, 0, 32'h12345678, 32'h0,        0, 32'h12345678, 0));
    tbl.push_back(mk("T5_idle",    0, 0, 0, 2'b10, 0, 32'h0,        32'h0,        0, 32'h12345678, 0));

    do_reset(1'b0);
    foreach (tbl[i]) step(tbl[i]);

    // Store then reset (with a store pending during reset): the array must come back cleared
    step(mk("T6_sw10", 1, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h00000010, 0));
    step(mk("T6_lw10", 1, 1, 0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 0));
    do_reset(1'b1);
    step(mk("T6_lw10_after", 1, 1, 0, 2'b10, 0, 32'h10, 32'h0,  0, 32'h00000000, 0));
    step(mk("T6_lw10_le",    1, 1, 0, 2'b10, 0, 32'h10, 32'h0,  1, 32'h00000000, 0));

    // Randomized traffic concentrated on a small window so loads often hit recent stores
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      asel = int'($urandom_range(0, 15));
      r      = mk("rand", 1, 0, 0, 2'b00, 0, 32'h0, 32'h0, -1, 32'h0, 0);
      r.v    = ($urandom_range(0, 9) != 0);
      r.rd   = (kind <= 3) || (kind == 8) || (kind == 9);
      r.wr   = (kind >= 4 && kind <= 6) || (kind == 8);
      r.sz   = ($urandom_range(0, 7) != 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      r.uns  = 1'($urandom_range(0, 1));
      r.addr = (asel == 0) ? $urandom : (asel == 1) ? 32'($urandom_range(248, 263))
                                                    : 32'($urandom_range(0, 63));
      r.sd   = $urandom;
      step(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
